// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: divides clk into the mic bit clock, samples the data
// line once per bit and delivers boxcar ones-counts over valid/ready.
module pdm_mic_capture #(
   parameter int CLK_DIV      = 100,
   parameter int DECIM        = 64,
   parameter int WARMUP_WORDS = 4,
   parameter int PCM_W        = $clog2(DECIM + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             mic_data,
   output logic             mic_clk,
   output logic             mic_lrsel,
   output logic [PCM_W-1:0] pcm_data,
   output logic             pcm_valid,
   input  logic             pcm_ready,
   output logic             overrun
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int BIT_W  = $clog2(DECIM);
   localparam int WARM_W = (WARMUP_WORDS > 0) ? $clog2(WARMUP_WORDS + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [PCM_W-1:0]   acc_q, acc_d;
   logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
   logic               mic_clk_q, mic_clk_d;
   logic [PCM_W-1:0]   pcm_data_q, pcm_data_d;
   logic               pcm_valid_q, pcm_valid_d;
   logic               overrun_q, overrun_d;

   logic               strobe;
   logic               word_done;
   logic [PCM_W-1:0]   word;

   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      acc_d       = acc_q;
      warm_cnt_d  = warm_cnt_q;
      pcm_data_d  = pcm_data_q;
      pcm_valid_d = pcm_valid_q;
      overrun_d   = overrun_q;

      strobe    = (state_q != IDLE) && (div_cnt_q == DIV_W'(CLK_DIV - 1));
      word_done = strobe && (bit_cnt_q == BIT_W'(DECIM - 1));
      word      = acc_q + PCM_W'(mic_data);

      if (!enable) begin
         state_d     = IDLE;
         div_cnt_d   = '0;
         bit_cnt_d   = '0;
         acc_d       = '0;
         warm_cnt_d  = '0;
         pcm_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = (WARMUP_WORDS == 0) ? RUN : WARMUP;
               div_cnt_d  = '0;
               bit_cnt_d  = '0;
               acc_d      = '0;
               warm_cnt_d = '0;
               overrun_d  = 1'b0;
            end
            default: begin
               div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
               if (word_done) begin
                  acc_d     = '0;
                  bit_cnt_d = '0;
               end else if (strobe) begin
                  acc_d     = word;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end

               if (state_q == WARMUP) begin
                  if (word_done) begin
                     warm_cnt_d = warm_cnt_q + 1'b1;
                     if (warm_cnt_q == WARM_W'(WARMUP_WORDS - 1))
                        state_d = RUN;
                  end
               end else begin
                  // Handshake first, so a completion in the same cycle is a clean replace.
                  if (pcm_valid_q && pcm_ready)
                     pcm_valid_d = 1'b0;
                  if (word_done) begin
                     if (!pcm_valid_q || pcm_ready) begin
                        pcm_data_d  = word;
                        pcm_valid_d = 1'b1;
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end
               end
            end
         endcase
      end

      // Look-ahead so the registered mic_clk matches the phase of div_cnt_d.
      mic_clk_d = (state_d != IDLE) && (div_cnt_d < DIV_W'(CLK_DIV / 2));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         acc_q       <= '0;
         warm_cnt_q  <= '0;
         mic_clk_q   <= 1'b0;
         pcm_data_q  <= '0;
         pcm_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         acc_q       <= acc_d;
         warm_cnt_q  <= warm_cnt_d;
         mic_clk_q   <= mic_clk_d;
         pcm_data_q  <= pcm_data_d;
         pcm_valid_q <= pcm_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign mic_clk   = mic_clk_q;
   assign mic_lrsel = 1'b0;
   assign pcm_data  = pcm_data_q;
   assign pcm_valid = pcm_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture with CLK_DIV=4, DECIM=8, WARMUP_WORDS=1.
// A mic model shifts a per-word bit pattern out on each mic_clk rising edge.
module tb_pdm_mic_capture;

   localparam int CLK_DIV      = 4;
   localparam int DECIM        = 8;
   localparam int WARMUP_WORDS = 1;
   localparam int PCM_W        = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             mic_data;
   logic             mic_clk;
   logic             mic_lrsel;
   logic [PCM_W-1:0] pcm_data;
   logic             pcm_valid;
   logic             pcm_ready;
   logic             overrun;

   int               errors = 0;
   int               checks = 0;
   logic [7:0]       pat = 8'hFF;
   int               bit_idx = 0;

   typedef struct {
      logic [7:0] pat;
      int         exp;
   } vec_t;

   vec_t tbl[6];
   int   mc_exp[4];

   pdm_mic_capture #(
      .CLK_DIV      (CLK_DIV),
      .DECIM        (DECIM),
      .WARMUP_WORDS (WARMUP_WORDS),
      .PCM_W        (PCM_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mic_data  (mic_data),
      .mic_clk   (mic_clk),
      .mic_lrsel (mic_lrsel),
      .pcm_data  (pcm_data),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Mic model: new bit presented just after each mic_clk rising edge.
   initial begin
      mic_data = 1'b0;
      forever begin
         @(posedge mic_clk);
         #1;
         mic_data = pat[bit_idx % 8];
         bit_idx++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!pcm_valid && n < 300);
      checks++;
      if (!pcm_valid) begin
         errors++;
         $display("FAIL %s: pcm_valid got 0 after %0d cycles, want 1", name, n);
      end
   endtask

   initial begin
      int n;

      tbl[0] = '{8'hFF, 8};
      tbl[1] = '{8'h00, 0};
      tbl[2] = '{8'h55, 4};
      tbl[3] = '{8'h07, 3};
      tbl[4] = '{8'h80, 1};
      tbl[5] = '{8'h7F, 7};
      mc_exp = '{1, 1, 0, 0};

      // Reset state
      reset     = 1'b1;
      enable    = 1'b0;
      pcm_ready = 1'b0;
      #1 reset  = 1'b0;
      #2;
      chk("rst_mic_clk", mic_clk, 0);
      chk("rst_pcm_data", pcm_data, 0);
      chk("rst_pcm_valid", pcm_valid, 0);
      chk("rst_overrun", overrun, 0);
      #20 reset = 1'b1;
      repeat (3) tick();
      chk("idle_mic_clk", mic_clk, 0);
      chk("idle_pcm_valid", pcm_valid, 0);

      // Enable: clock phase and first-word latency (cycle 65)
      pat     = 8'hFF;
      bit_idx = 0;
      enable  = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (n <= 8) chk("mic_clk_phase", mic_clk, mc_exp[(n - 1) % 4]);
      end while (!pcm_valid && n < 300);
      chk("first_valid_cycle", n, 65);
      chk("first_word_ones", pcm_data, 8);
      chk("mic_lrsel", mic_lrsel, 0);

      // Ready in the completion cycle replaces the held word without overrun
      tick(); tick();
      pat = 8'h00;
      repeat (29) tick();
      chk("pre_replace_valid", pcm_valid, 1);
      chk("pre_replace_data", pcm_data, 8);
      pcm_ready = 1'b1;
      tick();
      chk("replace_valid", pcm_valid, 1);
      chk("replace_data", pcm_data, 1);
      chk("replace_overrun", overrun, 0);
      pcm_ready = 1'b0;

      // Stalled consumer: next completion is dropped and overrun sticks
      repeat (31) tick();
      chk("pre_drop_overrun", overrun, 0);
      tick();
      chk("drop_overrun", overrun, 1);
      chk("drop_valid", pcm_valid, 1);
      chk("drop_data_held", pcm_data, 1);
      tick(); tick();
      pat       = 8'hFF;
      pcm_ready = 1'b1;
      tick();
      chk("consume_valid", pcm_valid, 0);
      chk("consume_data_held", pcm_data, 1);
      pcm_ready = 1'b0;
      repeat (28) tick();
      chk("gap_valid", pcm_valid, 0);
      tick();
      chk("reload_valid", pcm_valid, 1);
      chk("reload_data", pcm_data, 7);
      chk("reload_overrun", overrun, 1);

      // Disable mid-word (bit_cnt=5), then re-enable from scratch
      repeat (21) tick();
      enable = 1'b0;
      tick();
      chk("dis_mic_clk", mic_clk, 0);
      chk("dis_pcm_valid", pcm_valid, 0);
      chk("dis_overrun_held", overrun, 1);
      repeat (3) tick();
      chk("dis_mic_clk_idle", mic_clk, 0);
      pat     = 8'h07;
      bit_idx = 0;
      enable  = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (n == 1) chk("reen_overrun_clr", overrun, 0);
      end while (!pcm_valid && n < 300);
      chk("reen_valid_cycle", n, 65);
      chk("reen_word", pcm_data, 3);

      // Table of bit patterns, consumer always ready
      pcm_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_valid("tbl_sync", n);
         tick(); tick();
         pat = tbl[i].pat;
         wait_valid("tbl_mixed", n);
         wait_valid("tbl_word_valid", n);
         chk("tbl_word", pcm_data, tbl[i].exp);
      end

      // Asynchronous reset mid-run with a word pending
      pcm_ready = 1'b0;
      wait_valid("pre_reset_valid", n);
      #3;
      reset  = 1'b0;
      enable = 1'b0;
      #1;
      chk("async_rst_mic_clk", mic_clk, 0);
      chk("async_rst_pcm_data", pcm_data, 0);
      chk("async_rst_pcm_valid", pcm_valid, 0);
      chk("async_rst_overrun", overrun, 0);
      #2 reset = 1'b1;
      repeat (4) tick();
      chk("post_rst_mic_clk", mic_clk, 0);
      chk("post_rst_pcm_valid", pcm_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
